// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback block.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    // One queued register write: destination register and its data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, hazard query and register-file write port of the writeback block.
interface regfile_writeback_if
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = REG_DW,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) ();

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] chk_reg;
    logic          chk_pending;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          write_enable;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  chk_reg,
        output alu_ready, mem_ready, chk_pending,
        output write_reg, write_data, write_enable, fifo_count
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output chk_reg,
        input  alu_ready, mem_ready, chk_pending,
        input  write_reg, write_data, write_enable, fifo_count
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order writeback FIFO: up to two pushes and one pop per cycle, plus a
// parallel compare of every valid entry against a queried register number.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push0,
    input  wb_entry_t         push0_entry,
    input  logic              push1,
    input  wb_entry_t         push1_entry,
    input  logic              pop,
    output wb_entry_t         head,
    output logic [CW-1:0]     count,
    input  logic [REG_AW-1:0] chk_reg,
    output logic              chk_match
);

    wb_entry_t          entries [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      wr_ptr1;
    logic [1:0]         n_push;

    assign wr_ptr1 = wr_ptr + PW'(1);
    assign n_push  = {1'b0, push0} + {1'b0, push1};
    assign head    = entries[rd_ptr];

    // Pointer, occupancy and per-entry valid tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (push0) valid[wr_ptr]  <= 1'b1;
            if (push1) valid[wr_ptr1] <= 1'b1;
            wr_ptr <= wr_ptr + PW'(n_push);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Entry storage; second push lands in the slot after the first.
    always_ff @(posedge clk) begin
        if (rst_n && push0) entries[wr_ptr]  <= push0_entry;
        if (rst_n && push1) entries[wr_ptr1] <= push1_entry;
    end

    // Any valid entry targeting the queried register.
    always_comb begin
        chk_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].rd == chk_reg)) chk_match = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writeback: arbitrates ALU and load results into an in-order
// FIFO, drops register-0 writes, and drains one registered write per cycle.
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = REG_AW,
    parameter int unsigned DW    = REG_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_writeback_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          mem_ready;
    logic          alu_ready;
    logic          mem_push;
    logic          alu_push;
    logic          push0;
    logic          push1;
    logic          pop;
    wb_entry_t     push0_entry;
    wb_entry_t     push1_entry;
    wb_entry_t     head;
    logic          fifo_match;
    logic          write_enable_q;
    logic [AW-1:0] write_reg_q;
    logic [DW-1:0] write_data_q;

    // Free slots exclude any entry being popped this cycle; loads get first claim.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) | (mem_ready & ~bus.mem_valid);

    // Register-0 results complete the handshake but never occupy the FIFO.
    assign mem_push = bus.mem_valid & mem_ready & (bus.mem_reg != AW'(REG_ZERO));
    assign alu_push = bus.alu_valid & alu_ready & (bus.alu_reg != AW'(REG_ZERO));
    assign push0    = mem_push | alu_push;
    assign push1    = mem_push & alu_push;
    assign pop      = (count != '0);

    // Compact accepted results into push slots, load ahead of ALU.
    always_comb begin
        push0_entry.rd   = mem_push ? REG_AW'(bus.mem_reg)  : REG_AW'(bus.alu_reg);
        push0_entry.data = mem_push ? REG_DW'(bus.mem_data) : REG_DW'(bus.alu_data);
        push1_entry.rd   = REG_AW'(bus.alu_reg);
        push1_entry.data = REG_DW'(bus.alu_data);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (push0),
        .push0_entry (push0_entry),
        .push1       (push1),
        .push1_entry (push1_entry),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .chk_reg     (REG_AW'(bus.chk_reg)),
        .chk_match   (fifo_match)
    );

    // Write-port register stage; reg/data hold when nothing drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
        end else if (pop) begin
            write_enable_q <= 1'b1;
            write_reg_q    <= AW'(head.rd);
            write_data_q   <= DW'(head.data);
        end else begin
            write_enable_q <= 1'b0;
        end
    end

    assign bus.mem_ready    = mem_ready;
    assign bus.alu_ready    = alu_ready;
    assign bus.fifo_count   = count;
    assign bus.write_enable = write_enable_q;
    assign bus.write_reg    = write_reg_q;
    assign bus.write_data   = write_data_q;
    assign bus.chk_pending  = (bus.chk_reg != AW'(REG_ZERO)) &
                              (fifo_match | (write_enable_q & (write_reg_q == bus.chk_reg)));

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side driver of the register-file write port (write_reg / write_data / write_enable).
- Collects results from two producers, the ALU result path and the memory-load path, each through a valid/ready handshake.
- Buffers the results in a small in-order FIFO and drains at most one register write per cycle.
- Exposes a pending-write query so hazard logic can stall reads of registers whose write is still in flight.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- AW, 5, register-number width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid & alu_ready.
- alu_reg  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  load result accepted this cycle when mem_valid & mem_ready.
- mem_reg  in  AW  load destination register.
- mem_data  in  DW  load data.
- chk_reg  in  AW  register number being queried by hazard logic.
- chk_pending  out  1  a write to chk_reg is queued or on the write port.
- write_reg  out  AW  regfile write register number.
- write_data  out  DW  regfile write data.
- write_enable  out  1  regfile write strobe.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst_n=0. It empties the FIFO and clears every output register.
  - write_enable=0, write_reg=0, write_data=0, fifo_count=0.
  - Reset wins over any simultaneous handshake or drain. Entries in flight are discarded and no write is issued.
- free = DEPTH - fifo_count. An entry popped in the same cycle is not credited to free.
- Ready rules (combinational):
  - mem_ready = (free ≥ 1).
  - alu_ready = (free ≥ 2) | ((free ≥ 1) & !mem_valid).
  - Load results have priority. With one free slot and both producers valid, only mem is accepted.
- Enqueue order: when both producers are accepted in the same cycle, the mem entry is pushed first and the alu entry second.
- Register-0 filter:
  - An accepted request with reg = 0 completes its handshake normally (ready follows the rules above).
  - It allocates no FIFO entry, changes no count and never produces a write.
- Drain, every cycle:
  - FIFO non-empty: pop the head into the output registers and set write_enable=1.
  - FIFO empty: write_enable=0. write_reg and write_data hold their last values.
- Latency:
  - A result accepted at edge k is in the FIFO after edge k.
  - It is popped at edge k+1, so write_enable is high for exactly the cycle following edge k+1 (minimum 2-edge latency).
- Ordering: writes reach the port strictly in acceptance order. Two queued writes to the same register both issue, so the later value ends up in the register.
- Push and pop in the same cycle: fifo_count changes by (pushes − 1).
- Pointers are DEPTH-modulo and wrap without gaps. fifo_count never exceeds DEPTH, because the ready rules prevent overflow.
- chk_pending (combinational) = 1 when chk_reg ≠ 0 and either:
  - a valid FIFO entry has reg == chk_reg, or
  - write_enable=1 and write_reg == chk_reg.
  - chk_reg = 0 always gives 0.
- Producers must hold reg and data stable while valid is high and ready is low. The block does not check this.

Decomposition:
- Shared package regfile_pkg:
  - constants: REG_AW=5, REG_DW=32, REG_ZERO=0.
  - struct wb_entry_t {reg, data}.
- One natural sub-module, wb_fifo: DEPTH-entry FIFO with 0/1/2 pushes per cycle and a parallel-compare port for the pending match.
- The top level holds the ready logic, the register-0 filter and the output register stage.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with alu_valid=1 → write_enable=0, fifo_count=0, chk_pending=0. After release, the first accepted write appears two edges later.
- Single write: alu_reg=5, alu_data=0xDEADBEEF for one cycle → write_enable=1 with write_reg=5 and write_data=0xDEADBEEF two edges later, for exactly one cycle. chk_pending(5)=1 from acceptance until that cycle ends.
- Simultaneous producers: mem r3=0x11 and alu r3=0x22 in the same cycle → two consecutive writes, r3=0x11 then r3=0x22. fifo_count peaks at 2.
- Backpressure: stall the drain by filling the FIFO with both producers valid every cycle → fifo_count never exceeds 4. With free=1 and both valid, mem_ready=1 and alu_ready=0. All writes emerge in acceptance order.
- Register 0: alu_reg=0, alu_data=0xFFFF_FFFF accepted → alu_ready=1, fifo_count unchanged, no write_enable pulse, chk_pending(0)=0.
- Reset mid-operation: 3 entries queued, then rst_n=0 for one edge → write_enable=0 and fifo_count=0 on the next cycle. None of the discarded writes ever appears.
